// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 640x480@60 VGA front end:
//   - horizontal/vertical timing, derived totals and sync windows
//   - tile-map geometry (32x32 px tiles, 20x15 grid, pipe row)
//   - 24-bit RGB colour type and the palette used by the renderer
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

  // Counter width covers 0..799 and 0..524.
  localparam int CNT_W = 10;

  // Horizontal timing in pixels.
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;      // 800
  localparam int H_SYNC_START = H_VIS + H_FP;                  // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;     // 751

  // Vertical timing in lines.
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;      // 525
  localparam int V_SYNC_START = V_VIS + V_FP;                  // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;     // 491

  // Tile map geometry.
  localparam int TILE_LOG2 = 5;
  localparam int TILE_W    = CNT_W - TILE_LOG2;                // tile index width
  localparam int TILE_COLS = H_VIS >> TILE_LOG2;               // 20
  localparam int TILE_ROWS = V_VIS >> TILE_LOG2;               // 15
  localparam int PIPE_ROW  = 7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
  localparam rgb_t RGB_ROBOT = '{r: 8'd255, g: 8'd0,   b: 8'd0};
  localparam rgb_t RGB_WALL  = '{r: 8'd128, g: 8'd128, b: 8'd128};
  localparam rgb_t RGB_PIPE  = '{r: 8'd0,   g: 8'd200, b: 8'd0};
  localparam rgb_t RGB_FLOOR = '{r: 8'd32,  g: 8'd32,  b: 8'd96};

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel/line counters with registered, counter-aligned sync outputs.
// Ports:
//   i_clk       pixel clock (one pixel per rising edge)
//   i_srst      synchronous active-high reset, restarts frame at (0,0)
//   o_pixel_x   column counter 0..799
//   o_pixel_y   line counter 0..524
//   o_hs        horizontal sync, active low for x in 656..751
//   o_vs        vertical sync, active low for y in 490..491
//   o_video_on  1 while inside the 640x480 visible area
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_srst,
  output logic [CNT_W-1:0] o_pixel_x,
  output logic [CNT_W-1:0] o_pixel_y,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_video_on
);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;

  logic             w_line_end;
  logic [CNT_W-1:0] w_x_next;
  logic [CNT_W-1:0] w_y_next;
  logic             w_hs_next;
  logic             w_vs_next;

  // Sync is decoded from the *next* counter values so that the registered
  // sync lines up with the registered counters on the same cycle.
  always_comb begin
    w_line_end = (r_x == CNT_W'(H_TOTAL - 1));
    w_x_next   = w_line_end ? '0 : r_x + 1'b1;
    w_y_next   = r_y;
    if (w_line_end) begin
      w_y_next = (r_y == CNT_W'(V_TOTAL - 1)) ? '0 : r_y + 1'b1;
    end
    w_hs_next = !((w_x_next >= CNT_W'(H_SYNC_START)) &&
                  (w_x_next <= CNT_W'(H_SYNC_END)));
    w_vs_next = !((w_y_next >= CNT_W'(V_SYNC_START)) &&
                  (w_y_next <= CNT_W'(V_SYNC_END)));
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
    end else begin
      r_x  <= w_x_next;
      r_y  <= w_y_next;
      r_hs <= w_hs_next;
      r_vs <= w_vs_next;
    end
  end

  assign o_pixel_x  = r_x;
  assign o_pixel_y  = r_y;
  assign o_hs       = r_hs;
  assign o_vs       = r_vs;
  assign o_video_on = (r_x < CNT_W'(H_VIS)) && (r_y < CNT_W'(V_VIS));

endmodule

// File: rtl/vga_sync_graphics.sv
// ---------------------------------------------------------------------------
// vga_sync_graphics
// 640x480@60 VGA front end for the pipe-cleaning robot: timing generator
// plus a combinational tile-map renderer (32x32 px tiles, 20x15 grid).
// Ports:
//   clock_25            pixel clock
//   reset_key           synchronous active-high reset
//   robot_x / robot_y   robot tile column (0..19) / row (0..14), used live
//   vga_hs / vga_vs     active-low syncs, registered with the counters
//   video_on            visible-area flag
//   pixel_x / pixel_y   current pixel coordinates
//   vga_r/vga_g/vga_b   pixel colour, zero latency w.r.t. pixel_x/pixel_y
// Build option:
//   GRID_LINES_EN  when defined, the first row/column of every tile in the
//                  visible area is drawn black (robot red still wins).
// ---------------------------------------------------------------------------
module vga_sync_graphics
  import vga_pkg::*;
(
  input  logic             clock_25,
  input  logic             reset_key,
  input  logic [4:0]       robot_x,
  input  logic [3:0]       robot_y,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  logic              w_video_on;
  logic [TILE_W-1:0] w_tx;
  logic [TILE_W-1:0] w_ty;
  logic              w_robot_valid;
  logic              w_robot_hit;
  logic              w_wall;
  rgb_t              w_rgb;

  vga_timing u_timing (
    .i_clk      (clock_25),
    .i_srst     (reset_key),
    .o_pixel_x  (pixel_x),
    .o_pixel_y  (pixel_y),
    .o_hs       (vga_hs),
    .o_vs       (vga_vs),
    .o_video_on (w_video_on)
  );

  assign video_on = w_video_on;

  assign w_tx = pixel_x[CNT_W-1:TILE_LOG2];
  assign w_ty = pixel_y[CNT_W-1:TILE_LOG2];

  // Out-of-grid robot coordinates suppress the robot entirely.
  assign w_robot_valid = (robot_x < 5'(TILE_COLS)) && (robot_y < 4'(TILE_ROWS));
  assign w_robot_hit   = w_robot_valid && (w_tx == TILE_W'(robot_x)) &&
                         (w_ty == TILE_W'(robot_y));
  assign w_wall        = (w_tx == '0) || (w_tx == TILE_W'(TILE_COLS - 1)) ||
                         (w_ty == '0) || (w_ty == TILE_W'(TILE_ROWS - 1));

  // Colour priority: blanking, robot, (grid), wall, pipe row, floor.
  always_comb begin
    w_rgb = RGB_FLOOR;
    if (!w_video_on) begin
      w_rgb = RGB_BLACK;
    end else if (w_robot_hit) begin
      w_rgb = RGB_ROBOT;
    end
`ifdef GRID_LINES_EN
    else if ((pixel_x[TILE_LOG2-1:0] == '0) || (pixel_y[TILE_LOG2-1:0] == '0)) begin
      w_rgb = RGB_BLACK;
    end
`endif
    else if (w_wall) begin
      w_rgb = RGB_WALL;
    end else if (w_ty == TILE_W'(PIPE_ROW)) begin
      w_rgb = RGB_PIPE;
    end
  end

  assign vga_r = w_rgb.r;
  assign vga_g = w_rgb.g;
  assign vga_b = w_rgb.b;

endmodule

// File: tb/tb_vga_sync_graphics.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_graphics
// Self-checking bench for vga_sync_graphics. Every pixel is compared with a
// reference model built from plain arithmetic on the pixel position (tile =
// coordinate / 32). Robot inputs change at random instants; a table of fixed
// points pins the robot and checks literal colours. Hand-written sequences
// cover the first line, one full frame and a mid-frame reset.
// Honours GRID_LINES_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_vga_sync_graphics;

  logic       clock_25 = 1'b0;
  logic       reset_key;
  logic [4:0] robot_x;
  logic [3:0] robot_y;
  logic       vga_hs, vga_vs, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_sync_graphics dut (
    .clock_25 (clock_25),
    .reset_key(reset_key),
    .robot_x  (robot_x),
    .robot_y  (robot_y),
    .vga_hs   (vga_hs),
    .vga_vs   (vga_vs),
    .video_on (video_on),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b)
  );

  always #5 clock_25 = ~clock_25;

  typedef struct {
    int          px;
    int          py;
    logic [4:0]  rx;
    logic [3:0]  ry;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t tbl[12];
  int   n_tbl = 0;

  int n_vec = 0;
  int n_mis = 0;
  int mx = 0;   // model pixel position
  int my = 0;

  function automatic logic [23:0] model_rgb(int x, int y, int rx, int ry);
    int tx = x / 32;
    int ty = y / 32;
    if (!(x < 640 && y < 480)) return 24'h000000;
    if (rx < 20 && ry < 15 && tx == rx && ty == ry) return 24'hFF0000;
`ifdef GRID_LINES_EN
    if (x % 32 == 0 || y % 32 == 0) return 24'h000000;
`endif
    if (tx == 0 || tx == 19 || ty == 0 || ty == 14) return 24'h808080;
    if (ty == 7) return 24'h00C800;
    return 24'h202060;
  endfunction

  task automatic add_vec(int px, int py, int rx, int ry, logic [23:0] e);
    tbl[n_tbl].px      = px;
    tbl[n_tbl].py      = py;
    tbl[n_tbl].rx      = 5'(rx);
    tbl[n_tbl].ry      = 4'(ry);
    tbl[n_tbl].exp_rgb = e;
    n_tbl++;
  endtask

  task automatic expect_eq(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One rising edge; the model follows the reset value seen at that edge.
  task automatic tick();
    @(posedge clock_25);
    if (reset_key) begin
      mx = 0;
      my = 0;
    end else if (mx == 799) begin
      mx = 0;
      my = (my == 524) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    #1;
  endtask

  task automatic check_pixel();
    logic        ehs, evs, evid;
    logic [23:0] ergb, grgb;
    ehs  = !(mx >= 656 && mx <= 751);
    evs  = !(my >= 490 && my <= 491);
    evid = (mx < 640) && (my < 480);
    ergb = model_rgb(mx, my, int'(robot_x), int'(robot_y));
    grgb = {vga_r, vga_g, vga_b};
    n_vec++;
    if (int'(pixel_x) != mx || int'(pixel_y) != my || vga_hs != ehs ||
        vga_vs != evs || video_on != evid || grgb != ergb) begin
      n_mis++;
      $display("FAIL pixel(%0d,%0d) robot(%0d,%0d): got x=%0d y=%0d hs=%b vs=%b vid=%b rgb=%h, want hs=%b vs=%b vid=%b rgb=%h",
               mx, my, robot_x, robot_y, pixel_x, pixel_y, vga_hs, vga_vs,
               video_on, grgb, ehs, evs, evid, ergb);
    end
  endtask

  // Pin the robot at table points, otherwise occasionally move it at random
  // (including out-of-grid values), then compare the current pixel.
  task automatic drive_and_check();
    int hit = -1;
    for (int i = 0; i < n_tbl; i++) begin
      if (tbl[i].px == mx && tbl[i].py == my) hit = i;
    end
    if (hit >= 0) begin
      robot_x = tbl[hit].rx;
      robot_y = tbl[hit].ry;
    end else if ($urandom_range(0, 127) == 0) begin
      robot_x = 5'($urandom_range(0, 31));
      robot_y = 4'($urandom_range(0, 15));
    end
    #1;
    check_pixel();
    if (hit >= 0) begin
      n_vec++;
      if ({vga_r, vga_g, vga_b} != tbl[hit].exp_rgb) begin
        n_mis++;
        $display("FAIL table(%0d,%0d): got rgb=%h, want %h", mx, my,
                 {vga_r, vga_g, vga_b}, tbl[hit].exp_rgb);
      end
    end
  endtask

  initial begin
    int hs_low = 0;
    int vs_low = 0;
    int guard  = 0;

    add_vec(170, 100, 5, 3,  24'hFF0000);
    add_vec(300, 230, 5, 3,  24'h00C800);
    add_vec(300, 100, 5, 3,  24'h202060);
    add_vec(700, 100, 5, 3,  24'h000000);
    add_vec(100, 500, 5, 3,  24'h000000);
    add_vec(160, 96,  5, 3,  24'hFF0000);
    add_vec(620, 470, 19, 14, 24'hFF0000);
    add_vec(639, 479, 0, 0,  24'h808080);
    add_vec(640, 479, 19, 14, 24'h000000);
`ifdef GRID_LINES_EN
    add_vec(0,   0,   5, 3,  24'h000000);
    add_vec(64,  100, 5, 3,  24'h000000);
`else
    add_vec(0,   0,   5, 3,  24'h808080);
    add_vec(64,  100, 5, 3,  24'h202060);
`endif

    reset_key = 1'b1;
    robot_x   = 5'd5;
    robot_y   = 4'd3;
    tick();
    tick();
    reset_key = 1'b0;

    // Reset state.
    expect_eq("reset pixel_x", int'(pixel_x), 0);
    expect_eq("reset pixel_y", int'(pixel_y), 0);
    expect_eq("reset vga_hs", int'(vga_hs), 1);
    expect_eq("reset vga_vs", int'(vga_vs), 1);
    expect_eq("reset video_on", int'(video_on), 1);
    drive_and_check();

    // One full frame, every pixel checked.
    for (int i = 0; i < 420000; i++) begin
      tick();
      drive_and_check();
      if (i < 800 && !vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (i == 798) begin
        expect_eq("line end pixel_x", int'(pixel_x), 799);
        expect_eq("line end pixel_y", int'(pixel_y), 0);
      end
      if (i == 799) begin
        expect_eq("line wrap pixel_x", int'(pixel_x), 0);
        expect_eq("line wrap pixel_y", int'(pixel_y), 1);
      end
    end
    expect_eq("hsync low cycles line 0", hs_low, 96);
    expect_eq("vsync low cycles per frame", vs_low, 1600);
    expect_eq("frame wrap pixel_x", int'(pixel_x), 0);
    expect_eq("frame wrap pixel_y", int'(pixel_y), 0);

    // Mid-frame reset at (400,300).
    while (!(mx == 400 && my == 300) && guard < 300000) begin
      tick();
      drive_and_check();
      guard++;
    end
    expect_eq("reached pixel (400,300)", int'(mx == 400 && my == 300), 1);
    reset_key = 1'b1;
    tick();
    reset_key = 1'b0;
    expect_eq("mid reset pixel_x", int'(pixel_x), 0);
    expect_eq("mid reset pixel_y", int'(pixel_y), 0);
    expect_eq("mid reset vga_hs", int'(vga_hs), 1);
    expect_eq("mid reset vga_vs", int'(vga_vs), 1);
    drive_and_check();
    for (int i = 0; i < 10; i++) begin
      tick();
      drive_and_check();
    end
    expect_eq("post reset pixel_x", int'(pixel_x), 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
